i2c_slave: RTL

- I2C target (responder) for the same two-wire bus driven by the team's I2C master. Oversamples SCL/SDA on the system clock.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- Write transfers: pushes received bytes to an RX FIFO. Read transfers: pulls bytes from a TX FIFO and shifts them out.
- Drives SDA open-drain only; never drives SCL (no clock stretching).

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_slave_if.sv | 24 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_slave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding, ACK levels and field widths
package i2c_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ADDR       = 3'd1;
    localparam logic [2:0] S_ADDR_ACK   = 3'd2;
    localparam logic [2:0] S_WRITE_DATA = 3'd3;
    localparam logic [2:0] S_WRITE_ACK  = 3'd4;
    localparam logic [2:0] S_READ_DATA  = 3'd5;
    localparam logic [2:0] S_READ_ACK   = 3'd6;
    localparam logic [2:0] S_IGNORE     = 3'd7;

    typedef enum logic [2:0] {
        IDLE       = S_IDLE,
        ADDR       = S_ADDR,
        ADDR_ACK   = S_ADDR_ACK,
        WRITE_DATA = S_WRITE_DATA,
        WRITE_ACK  = S_WRITE_ACK,
        READ_DATA  = S_READ_DATA,
        READ_ACK   = S_READ_ACK,
        IGNORE     = S_IGNORE
    } state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - bus pins and FIFO handshakes of the I2C target
interface i2c_slave_if;

    logic                          scl_in;
    logic                          sda_in;
    logic                          sda_oe;
    logic [i2c_pkg::DATA_BITS-1:0] tx_data;
    logic                          tx_valid;
    logic                          fifo_tx_rd_en;
    logic [i2c_pkg::DATA_BITS-1:0] rx_data;
    logic                          fifo_rx_wr_en;
    logic                          rx_full;

    modport slave (
        input  scl_in, sda_in, tx_data, tx_valid, rx_full,
        output sda_oe, fifo_tx_rd_en, rx_data, fifo_rx_wr_en
    );

    modport master (
        output scl_in, sda_in, tx_data, tx_valid, rx_full,
        input  sda_oe, fifo_tx_rd_en, rx_data, fifo_rx_wr_en
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge, START and STOP pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    // Idle bus is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: address match, RX push on writes, TX pop on reads
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 i2c_reset,
    input  logic [ADDR_BITS-1:0] own_addr,
    i2c_slave_if.slave           bus,
    output logic                 busy,
    output logic                 rw
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (i2c_reset),
        .scl_i      (bus.scl_in),
        .sda_i      (bus.sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e               state_q, state_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic                 sda_oe_q, sda_oe_d, rx_wr_q, rx_wr_d, tx_rd_q, tx_rd_d;
    logic                 busy_q, busy_d, rw_q, rw_d, ack_ok_q, ack_ok_d, done_q, done_d;
    logic                 do_load;
    logic [DATA_BITS-1:0] shift_in, load_byte;

    assign shift_in  = {shift_q[DATA_BITS-2:0], sda_s};
    assign load_byte = bus.tx_valid ? bus.tx_data : IDLE_BYTE;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        sda_oe_d  = sda_oe_q;
        rx_wr_d   = 1'b0;
        tx_rd_d   = 1'b0;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ack_ok_d  = ack_ok_q;
        done_d    = done_q;
        do_load   = 1'b0;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = 3'd7;
            sda_oe_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d  = shift_in;
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0) begin
                        if (shift_q[ADDR_BITS-1:0] == own_addr) begin
                            rw_d    = sda_s;
                            busy_d  = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                // First fall drives the ACK, second fall ends the ACK slot.
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        do_load = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 3'd7;
                        done_d   = 1'b0;
                        state_d  = WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_q - 3'd1;
                        if (bitcnt_q == 3'd0) begin
                            done_d   = 1'b1;
                            ack_ok_d = ~bus.rx_full;
                            if (!bus.rx_full) begin
                                rx_wr_d   = 1'b1;
                                rx_data_d = shift_in;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        sda_oe_d = ack_ok_q;
                        state_d  = WRITE_ACK;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    done_d   = 1'b0;
                    bitcnt_d = 3'd7;
                    state_d  = ack_ok_q ? WRITE_DATA : IGNORE;
                end
                READ_DATA: if (scl_fall) begin
                    if (bitcnt_q == 3'd0) begin
                        sda_oe_d = 1'b0;
                        state_d  = READ_ACK;
                    end else begin
                        shift_d  = shift_q << 1;
                        sda_oe_d = ~shift_q[DATA_BITS-2];
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                READ_ACK: begin
                    if (scl_rise && sda_s == I2C_NACK) state_d = IGNORE;
                    else if (scl_fall)                 do_load = 1'b1;
                end
                default: ;
            endcase
            if (do_load) begin
                shift_d  = load_byte;
                sda_oe_d = ~load_byte[DATA_BITS-1];
                tx_rd_d  = bus.tx_valid;
                bitcnt_d = 3'd7;
                state_d  = READ_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge i2c_reset) begin
        if (i2c_reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            sda_oe_q  <= 1'b0;
            rx_wr_q   <= 1'b0;
            tx_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            sda_oe_q  <= sda_oe_d;
            rx_wr_q   <= rx_wr_d;
            tx_rd_q   <= tx_rd_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
        end
    end

    assign bus.sda_oe        = sda_oe_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.fifo_rx_wr_en = rx_wr_q;
    assign bus.fifo_tx_rd_en = tx_rd_q;
    assign busy              = busy_q;
    assign rw                = rw_q;

endmodule
